// File: rtl/ex_stage_csr_pkg.sv
// Shared encodings for the execute stage and its machine-mode CSR file.
package ex_stage_csr_pkg;

  localparam int XLEN = 64;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_PASSB  = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } alu_op_e;

  typedef enum logic [2:0] {
    CSR_NOP  = 3'b000,
    CSR_RW   = 3'b001,
    CSR_RS   = 3'b010,
    CSR_RC   = 3'b011,
    CSR_NOPI = 3'b100,
    CSR_RWI  = 3'b101,
    CSR_RSI  = 3'b110,
    CSR_RCI  = 3'b111
  } csr_op_e;

  typedef enum logic [1:0] {
    SRCB_BUSB = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10,
    SRCB_ZERO = 2'b11
  } alu_srcb_e;

  localparam logic [1:0]  MULOP_WORD = 2'b01;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [XLEN-1:0] MSTATUS_RST  = 64'h0000_000A_0000_1800;
  localparam logic [XLEN-1:0] MCAUSE_ECALL = 64'd11;

endpackage

// File: rtl/ex_csr_file.sv
// Machine-mode CSR file: mstatus, mtvec, mepc, mcause with read-modify-write ops.
module ex_csr_file
  import ex_stage_csr_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_wen,
  input  logic [2:0]      csr_op,
  input  logic [11:0]     csr_id,
  input  logic [XLEN-1:0] csr_datain,
  input  logic            ecall,
  input  logic [XLEN-1:0] epc_in,
  output logic [XLEN-1:0] csr_rdata,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mtvec
);

  logic [XLEN-1:0] mstatus_reg, mtvec_reg, mepc_reg, mcause_reg;
  logic [XLEN-1:0] wdata;
  logic            do_write;

  // Read mux always shows the value held before any write on this edge.
  always_comb begin
    csr_rdata = '0;
    case (csr_id)
      CSR_MSTATUS: csr_rdata = mstatus_reg;
      CSR_MTVEC:   csr_rdata = mtvec_reg;
      CSR_MEPC:    csr_rdata = mepc_reg;
      CSR_MCAUSE:  csr_rdata = mcause_reg;
      default:     csr_rdata = '0;
    endcase
  end

  // New value for the addressed CSR; register and immediate forms behave alike.
  always_comb begin
    do_write = 1'b0;
    wdata    = csr_rdata;
    case (csr_op_e'(csr_op))
      CSR_RW, CSR_RWI: begin do_write = 1'b1; wdata = csr_datain; end
      CSR_RS, CSR_RSI: begin do_write = 1'b1; wdata = csr_rdata | csr_datain; end
      CSR_RC, CSR_RCI: begin do_write = 1'b1; wdata = csr_rdata & ~csr_datain; end
      default:         begin do_write = 1'b0; wdata = csr_rdata; end
    endcase
  end

  // CSR state update; an ecall trap overrides whatever csr_op requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_reg <= MSTATUS_RST;
      mtvec_reg   <= '0;
      mepc_reg    <= '0;
      mcause_reg  <= '0;
    end else if (csr_wen) begin
      if (ecall) begin
        mepc_reg   <= epc_in;
        mcause_reg <= MCAUSE_ECALL;
      end else if (do_write) begin
        case (csr_id)
          CSR_MSTATUS: mstatus_reg <= wdata;
          CSR_MTVEC:   mtvec_reg   <= wdata;
          CSR_MEPC:    mepc_reg    <= wdata;
          CSR_MCAUSE:  mcause_reg  <= wdata;
          default:     ;
        endcase
      end
    end
  end

  assign mepc  = mepc_reg;
  assign mtvec = mtvec_reg;

endmodule

// File: rtl/ex_stage_csr.sv
// Execute stage: ID/EX pipeline register, RV64IM ALU on the registered operands,
// and the machine-mode CSR file used by the ID stage.
module ex_stage_csr
  import ex_stage_csr_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            enable,
  input  logic            valid_i,
  output logic            valid_o,
  input  logic [63:0]     pc_i,
  output logic [63:0]     pc_o,
  input  logic [31:0]     instr_i,
  output logic [31:0]     instr_o,
  input  logic [4:0]      rd_i,
  output logic [4:0]      rd_o,
  input  logic [63:0]     busa_i,
  output logic [63:0]     busa_o,
  input  logic [63:0]     busb_i,
  output logic [63:0]     busb_o,
  input  logic [63:0]     imm_i,
  output logic [63:0]     imm_o,
  input  logic [63:0]     csrres_i,
  output logic [63:0]     csrres_o,
  input  logic            ALUSrcA_i,
  output logic            ALUSrcA_o,
  input  logic [1:0]      ALUSrcB_i,
  output logic [1:0]      ALUSrcB_o,
  input  logic [4:0]      ALUOp_i,
  output logic [4:0]      ALUOp_o,
  input  logic [1:0]      MulOp_i,
  output logic [1:0]      MulOp_o,
  input  logic [2:0]      MemOp_i,
  output logic [2:0]      MemOp_o,
  input  logic            MemToReg_i,
  output logic            MemToReg_o,
  input  logic            MemWen_i,
  output logic            MemWen_o,
  input  logic            wen_i,
  output logic            wen_o,
  input  logic            CsrToReg_i,
  output logic            CsrToReg_o,
  input  logic            Ebreak_i,
  output logic            Ebreak_o,
  output logic [63:0]     alu_res,
  input  logic            csr_wen,
  input  logic [2:0]      csr_op,
  input  logic [11:0]     csr_id,
  input  logic [63:0]     csr_datain,
  input  logic            ecall,
  input  logic [63:0]     epc_in,
  output logic [63:0]     csr_rdata,
  output logic [63:0]     mepc_o,
  output logic [63:0]     mtvec_o
);

  // ID/EX register: clear beats capture, capture beats hold.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_o    <= 1'b0;
      pc_o       <= '0;
      instr_o    <= '0;
      rd_o       <= '0;
      busa_o     <= '0;
      busb_o     <= '0;
      imm_o      <= '0;
      csrres_o   <= '0;
      ALUSrcA_o  <= 1'b0;
      ALUSrcB_o  <= '0;
      ALUOp_o    <= '0;
      MulOp_o    <= '0;
      MemOp_o    <= '0;
      MemToReg_o <= 1'b0;
      MemWen_o   <= 1'b0;
      wen_o      <= 1'b0;
      CsrToReg_o <= 1'b0;
      Ebreak_o   <= 1'b0;
    end else if (enable) begin
      valid_o    <= valid_i;
      pc_o       <= pc_i;
      instr_o    <= instr_i;
      rd_o       <= rd_i;
      busa_o     <= busa_i;
      busb_o     <= busb_i;
      imm_o      <= imm_i;
      csrres_o   <= csrres_i;
      ALUSrcA_o  <= ALUSrcA_i;
      ALUSrcB_o  <= ALUSrcB_i;
      ALUOp_o    <= ALUOp_i;
      MulOp_o    <= MulOp_i;
      MemOp_o    <= MemOp_i;
      MemToReg_o <= MemToReg_i;
      MemWen_o   <= MemWen_i;
      wen_o      <= wen_i;
      CsrToReg_o <= CsrToReg_i;
      Ebreak_o   <= Ebreak_i;
    end
  end

  logic [63:0]  op_a, op_b, a_x, b_x, res64;
  logic         word, a_sgn, b_sgn;
  logic [5:0]   shamt;
  logic [127:0] prod;
  logic         div_zero, div_ovf;
  logic [63:0]  quot_s_raw, rem_s_raw, quot_s, rem_s, quot_u, rem_u;

  assign word = (MulOp_o == MULOP_WORD);

  // Operand selection from the registered datapath.
  always_comb begin
    op_a = ALUSrcA_o ? pc_o : busa_o;
    case (alu_srcb_e'(ALUSrcB_o))
      SRCB_BUSB: op_b = busb_o;
      SRCB_IMM:  op_b = imm_o;
      SRCB_FOUR: op_b = 64'd4;
      default:   op_b = '0;
    endcase
  end

  // Signedness of each operand; word ops narrow to 32 bits with this extension.
  always_comb begin
    a_sgn = 1'b1;
    b_sgn = 1'b1;
    case (alu_op_e'(ALUOp_o))
      ALU_SLTU, ALU_SRL, ALU_MULHU, ALU_DIVU, ALU_REMU: begin a_sgn = 1'b0; b_sgn = 1'b0; end
      ALU_MULHSU: begin a_sgn = 1'b1; b_sgn = 1'b0; end
      default:    begin a_sgn = 1'b1; b_sgn = 1'b1; end
    endcase
    a_x = op_a;
    b_x = op_b;
    if (word) begin
      a_x = {{32{a_sgn & op_a[31]}}, op_a[31:0]};
      b_x = {{32{b_sgn & op_b[31]}}, op_b[31:0]};
    end
    shamt = word ? {1'b0, b_x[4:0]} : b_x[5:0];
  end

  // One 128-bit product covers mul and all mulh flavours via operand extension.
  assign prod = {{64{a_sgn & a_x[63]}}, a_x} * {{64{b_sgn & b_x[63]}}, b_x};

  assign div_zero   = (b_x == '0);
  assign div_ovf    = (a_x == 64'h8000_0000_0000_0000) && (b_x == '1);
  assign quot_s_raw = $signed(a_x) / $signed(b_x);
  assign rem_s_raw  = $signed(a_x) % $signed(b_x);

  // Division corner cases follow the RISC-V defined results.
  always_comb begin
    if (div_zero) begin
      quot_s = '1;
      rem_s  = a_x;
    end else if (div_ovf) begin
      quot_s = a_x;
      rem_s  = '0;
    end else begin
      quot_s = quot_s_raw;
      rem_s  = rem_s_raw;
    end
    quot_u = div_zero ? '1  : a_x / b_x;
    rem_u  = div_zero ? a_x : a_x % b_x;
  end

  // ALU result before word-mode sign extension.
  always_comb begin
    case (alu_op_e'(ALUOp_o))
      ALU_ADD:    res64 = a_x + b_x;
      ALU_SUB:    res64 = a_x - b_x;
      ALU_SLL:    res64 = a_x << shamt;
      ALU_SLT:    res64 = {63'b0, $signed(a_x) < $signed(b_x)};
      ALU_SLTU:   res64 = {63'b0, a_x < b_x};
      ALU_XOR:    res64 = a_x ^ b_x;
      ALU_SRL:    res64 = a_x >> shamt;
      ALU_SRA:    res64 = $signed(a_x) >>> shamt;
      ALU_OR:     res64 = a_x | b_x;
      ALU_AND:    res64 = a_x & b_x;
      ALU_PASSB:  res64 = b_x;
      ALU_MUL:    res64 = prod[63:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: res64 = prod[127:64];
      ALU_DIV:    res64 = quot_s;
      ALU_DIVU:   res64 = quot_u;
      ALU_REM:    res64 = rem_s;
      ALU_REMU:   res64 = rem_u;
      default:    res64 = '0;
    endcase
  end

  assign alu_res = word ? {{32{res64[31]}}, res64[31:0]} : res64;

  ex_csr_file u_csr (
    .clk        (clk),
    .rst        (rst),
    .csr_wen    (csr_wen),
    .csr_op     (csr_op),
    .csr_id     (csr_id),
    .csr_datain (csr_datain),
    .ecall      (ecall),
    .epc_in     (epc_in),
    .csr_rdata  (csr_rdata),
    .mepc       (mepc_o),
    .mtvec      (mtvec_o)
  );

endmodule

// File: tb/tb_ex_stage_csr.sv
// Bench for ex_stage_csr: behavioural model checked every cycle plus directed literals.
module tb_ex_stage_csr;

  localparam int PW = 376;

  logic clk = 1'b0;
  logic rst, flush, enable, valid_i, valid_o;
  logic [63:0] pc_i, pc_o, busa_i, busa_o, busb_i, busb_o, imm_i, imm_o, csrres_i, csrres_o;
  logic [31:0] instr_i, instr_o;
  logic [4:0]  rd_i, rd_o, ALUOp_i, ALUOp_o;
  logic        ALUSrcA_i, ALUSrcA_o;
  logic [1:0]  ALUSrcB_i, ALUSrcB_o, MulOp_i, MulOp_o;
  logic [2:0]  MemOp_i, MemOp_o;
  logic        MemToReg_i, MemToReg_o, MemWen_i, MemWen_o, wen_i, wen_o;
  logic        CsrToReg_i, CsrToReg_o, Ebreak_i, Ebreak_o;
  logic [63:0] alu_res;
  logic        csr_wen, ecall;
  logic [2:0]  csr_op;
  logic [11:0] csr_id;
  logic [63:0] csr_datain, epc_in, csr_rdata, mepc_o, mtvec_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  ex_stage_csr dut (
    .clk(clk), .rst(rst), .flush(flush), .enable(enable),
    .valid_i(valid_i), .valid_o(valid_o), .pc_i(pc_i), .pc_o(pc_o),
    .instr_i(instr_i), .instr_o(instr_o), .rd_i(rd_i), .rd_o(rd_o),
    .busa_i(busa_i), .busa_o(busa_o), .busb_i(busb_i), .busb_o(busb_o),
    .imm_i(imm_i), .imm_o(imm_o), .csrres_i(csrres_i), .csrres_o(csrres_o),
    .ALUSrcA_i(ALUSrcA_i), .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_i(ALUSrcB_i), .ALUSrcB_o(ALUSrcB_o),
    .ALUOp_i(ALUOp_i), .ALUOp_o(ALUOp_o), .MulOp_i(MulOp_i), .MulOp_o(MulOp_o),
    .MemOp_i(MemOp_i), .MemOp_o(MemOp_o), .MemToReg_i(MemToReg_i), .MemToReg_o(MemToReg_o),
    .MemWen_i(MemWen_i), .MemWen_o(MemWen_o), .wen_i(wen_i), .wen_o(wen_o),
    .CsrToReg_i(CsrToReg_i), .CsrToReg_o(CsrToReg_o), .Ebreak_i(Ebreak_i), .Ebreak_o(Ebreak_o),
    .alu_res(alu_res), .csr_wen(csr_wen), .csr_op(csr_op), .csr_id(csr_id),
    .csr_datain(csr_datain), .ecall(ecall), .epc_in(epc_in), .csr_rdata(csr_rdata),
    .mepc_o(mepc_o), .mtvec_o(mtvec_o)
  );

  logic [PW-1:0] in_vec, out_vec;
  assign in_vec  = {valid_i, pc_i, instr_i, rd_i, busa_i, busb_i, imm_i, csrres_i, ALUSrcA_i,
                    ALUSrcB_i, ALUOp_i, MulOp_i, MemOp_i, MemToReg_i, MemWen_i, wen_i, CsrToReg_i, Ebreak_i};
  assign out_vec = {valid_o, pc_o, instr_o, rd_o, busa_o, busb_o, imm_o, csrres_o, ALUSrcA_o,
                    ALUSrcB_o, ALUOp_o, MulOp_o, MemOp_o, MemToReg_o, MemWen_o, wen_o, CsrToReg_o, Ebreak_o};

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [PW-1:0] m_pipe = '0;
  logic [63:0] m_pc = 0, m_busa = 0, m_busb = 0, m_imm = 0;
  logic        m_srca = 0;
  logic [1:0]  m_srcb = 0, m_mulop = 0;
  logic [4:0]  m_op = 0;
  logic [63:0] m_mstatus = 0, m_mtvec = 0, m_mepc = 0, m_mcause = 0;

  function automatic logic [63:0] ref_alu(input logic [63:0] a, input logic [63:0] b,
                                          input int op, input bit word);
    logic [31:0] a32, b32, r32;
    logic [63:0] r;
    logic signed [127:0] sa, sb;
    logic [127:0] ua, ub, p;
    int sh;
    r = 0; r32 = 0; p = 0;
    if (word) begin
      a32 = a[31:0]; b32 = b[31:0]; sh = int'(b[4:0]);
      case (op)
        0: r32 = a32 + b32;
        1: r32 = a32 - b32;
        2: r32 = a32 << sh;
        3: r32 = ($signed(a32) < $signed(b32)) ? 32'd1 : 32'd0;
        4: r32 = (a32 < b32) ? 32'd1 : 32'd0;
        5: r32 = a32 ^ b32;
        6: r32 = a32 >> sh;
        7: r32 = $signed(a32) >>> sh;
        8: r32 = a32 | b32;
        9: r32 = a32 & b32;
        10: r32 = b32;
        11: r32 = a32 * b32;
        12, 13, 14: begin
          sa = $signed(a32); sb = $signed(b32);
          ua = (op == 14) ? {96'b0, a32} : sa;
          ub = (op == 12) ? sb : {96'b0, b32};
          p = ua * ub;
          r32 = p[95:64];
        end
        15: if (b32 == 0) r32 = '1;
            else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
            else r32 = $signed(a32) / $signed(b32);
        16: if (b32 == 0) r32 = '1; else r32 = a32 / b32;
        17: if (b32 == 0) r32 = a32;
            else if (a32 == 32'h8000_0000 && b32 == '1) r32 = 0;
            else r32 = $signed(a32) % $signed(b32);
        18: if (b32 == 0) r32 = a32; else r32 = a32 % b32;
        default: r32 = 0;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      sh = int'(b[5:0]);
      case (op)
        0: r = a + b;
        1: r = a - b;
        2: r = a << sh;
        3: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
        4: r = (a < b) ? 64'd1 : 64'd0;
        5: r = a ^ b;
        6: r = a >> sh;
        7: r = $signed(a) >>> sh;
        8: r = a | b;
        9: r = a & b;
        10: r = b;
        11: r = a * b;
        12, 13, 14: begin
          sa = $signed(a); sb = $signed(b);
          ua = (op == 14) ? {64'b0, a} : sa;
          ub = (op == 12) ? sb : {64'b0, b};
          p = ua * ub;
          r = p[127:64];
        end
        15: if (b == 0) r = '1;
            else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
            else r = $signed(a) / $signed(b);
        16: if (b == 0) r = '1; else r = a / b;
        17: if (b == 0) r = a;
            else if (a == 64'h8000_0000_0000_0000 && b == '1) r = 0;
            else r = $signed(a) % $signed(b);
        18: if (b == 0) r = a; else r = a % b;
        default: r = 0;
      endcase
    end
    return r;
  endfunction

  function automatic logic [63:0] ref_csr(input logic [11:0] id);
    case (id)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [63:0] old, nv;
    bit wr;
    if (rst || flush) begin
      m_pipe = '0; m_pc = 0; m_busa = 0; m_busb = 0; m_imm = 0;
      m_srca = 0; m_srcb = 0; m_op = 0; m_mulop = 0;
    end else if (enable) begin
      m_pipe = in_vec; m_pc = pc_i; m_busa = busa_i; m_busb = busb_i; m_imm = imm_i;
      m_srca = ALUSrcA_i; m_srcb = ALUSrcB_i; m_op = ALUOp_i; m_mulop = MulOp_i;
    end
    if (rst) begin
      m_mstatus = 64'hA_0000_1800; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
    end else if (csr_wen && ecall) begin
      m_mepc = epc_in; m_mcause = 11;
    end else if (csr_wen) begin
      old = ref_csr(csr_id);
      wr = 1; nv = old;
      case (csr_op[1:0])
        2'd1: nv = csr_datain;
        2'd2: nv = old | csr_datain;
        2'd3: nv = old & ~csr_datain;
        default: wr = 0;
      endcase
      if (wr) begin
        if (csr_id == 12'h300) m_mstatus = nv;
        if (csr_id == 12'h305) m_mtvec = nv;
        if (csr_id == 12'h341) m_mepc = nv;
        if (csr_id == 12'h342) m_mcause = nv;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [63:0] ea, eb;
    if (checking) begin
      ea = m_srca ? m_pc : m_busa;
      case (m_srcb)
        2'd0: eb = m_busb;
        2'd1: eb = m_imm;
        2'd2: eb = 64'd4;
        default: eb = 64'd0;
      endcase
      check("model_pipe", out_vec, m_pipe);
      check("model_alu", alu_res, ref_alu(ea, eb, int'(m_op), m_mulop == 2'b01));
      check("model_rdata", csr_rdata, ref_csr(csr_id));
      check("model_mepc", mepc_o, m_mepc);
      check("model_mtvec", mtvec_o, m_mtvec);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_vec(input string name, input logic srca, input logic [1:0] srcb,
                         input logic [4:0] op, input logic [1:0] mulop, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] imm, input logic [63:0] pc,
                         input logic [63:0] exp);
    enable = 1; valid_i = 1;
    ALUSrcA_i = srca; ALUSrcB_i = srcb; ALUOp_i = op; MulOp_i = mulop;
    busa_i = a; busb_i = b; imm_i = imm; pc_i = pc;
    csrres_i = a ^ b; MemOp_i = op[2:0]; Ebreak_i = op[0]; wen_i = op[1];
    instr_i = {27'h0, op}; rd_i = op;
    tick();
    #1;
    check(name, alu_res, exp);
    $display("vec %s a=%0h b=%0h op=%0d mulop=%0d res=%0h", name, a, b, op, mulop, alu_res);
  endtask

  task automatic csr_cmd(input logic [11:0] id, input logic [2:0] op, input logic [63:0] d);
    csr_wen = 1; csr_id = id; csr_op = op; csr_datain = d;
    tick();
    csr_wen = 0;
    #1;
    $display("csr id=%0h op=%0d data=%0h -> mtvec=%0h mepc=%0h", id, op, d, mtvec_o, mepc_o);
  endtask

  initial begin
    rst = 1; flush = 0; enable = 0; valid_i = 0;
    pc_i = 0; instr_i = 0; rd_i = 0; busa_i = 0; busb_i = 0; imm_i = 0; csrres_i = 0;
    ALUSrcA_i = 0; ALUSrcB_i = 0; ALUOp_i = 0; MulOp_i = 0; MemOp_i = 0;
    MemToReg_i = 0; MemWen_i = 0; wen_i = 0; CsrToReg_i = 0; Ebreak_i = 0;
    csr_wen = 0; csr_op = 0; csr_id = 0; csr_datain = 0; ecall = 0; epc_in = 0;
    tick();
    checking = 1;
    tick();
    csr_id = 12'h300;
    #1;
    check("rst_mstatus", csr_rdata, 64'hA_0000_1800);
    check("rst_valid", valid_o, 0);
    check("rst_mtvec", mtvec_o, 0);
    $display("reset done mstatus=%0h", csr_rdata);
    rst = 0;

    // capture then hold
    valid_i = 1; enable = 1; busa_i = 5; imm_i = 64'hFFFF_FFFF_FFFF_FFFD;
    ALUSrcB_i = 2'b01; ALUOp_i = 0; pc_i = 64'h100; instr_i = 32'h13; rd_i = 3; MemToReg_i = 1; CsrToReg_i = 1;
    tick(); #1;
    check("load_valid", valid_o, 1);
    check("load_alu", alu_res, 64'd2);
    $display("load alu_res=%0h valid=%0b", alu_res, valid_o);
    enable = 0; valid_i = 0; busa_i = 100; imm_i = 0; pc_i = 64'h200;
    tick(); #1;
    check("hold_alu", alu_res, 64'd2);
    check("hold_valid", valid_o, 1);
    check("hold_pc", pc_o, 64'h100);
    $display("hold alu_res=%0h pc=%0h", alu_res, pc_o);

    // flush beats enable
    flush = 1; enable = 1; valid_i = 1; busa_i = 9;
    tick(); flush = 0; #1;
    check("flush_valid", valid_o, 0);
    check("flush_pc", pc_o, 0);
    check("flush_alu", alu_res, 0);
    $display("flush valid=%0b pc=%0h", valid_o, pc_o);
    MemToReg_i = 0; CsrToReg_i = 0;

    run_vec("addw", 0, 0, 0, 1, 64'h7FFF_FFFF, 64'd1, 0, 0, 64'hFFFF_FFFF_8000_0000);
    run_vec("sra63", 0, 0, 7, 0, 64'h8000_0000_0000_0000, 64'd63, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_vec("div0", 0, 0, 15, 0, 64'd7, 64'd0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_vec("rem0", 0, 0, 17, 0, 64'd7, 64'd0, 0, 0, 64'd7);
    run_vec("divovf", 0, 0, 15, 0, 64'h8000_0000_0000_0000, '1, 0, 0, 64'h8000_0000_0000_0000);
    run_vec("removf", 0, 0, 17, 0, 64'h8000_0000_0000_0000, '1, 0, 0, 64'd0);
    run_vec("divwovf", 0, 0, 15, 1, 64'h8000_0000, 64'hFFFF_FFFF, 0, 0, 64'hFFFF_FFFF_8000_0000);
    run_vec("sub", 0, 0, 1, 0, 64'd5, 64'd7, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE);
    run_vec("sltu", 0, 0, 4, 0, 64'd1, '1, 0, 0, 64'd1);
    run_vec("slt", 0, 0, 3, 0, '1, 64'd1, 0, 0, 64'd1);
    run_vec("mulhu", 0, 0, 14, 0, '1, '1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE);
    run_vec("mulh", 0, 0, 12, 0, '1, '1, 0, 0, 64'd0);
    run_vec("mul", 0, 0, 11, 0, 64'd3, 64'd5, 0, 0, 64'd15);
    run_vec("sll63", 0, 0, 2, 0, 64'd1, 64'd63, 0, 0, 64'h8000_0000_0000_0000);
    run_vec("sllw", 0, 0, 2, 1, 64'd1, 64'd63, 0, 0, 64'hFFFF_FFFF_8000_0000);
    run_vec("srlw", 0, 0, 6, 1, 64'hFFFF_FFFF_8000_0000, 64'd4, 0, 0, 64'h0800_0000);
    run_vec("divu", 0, 0, 16, 0, 64'd20, 64'd3, 0, 0, 64'd6);
    run_vec("remu", 0, 0, 18, 0, 64'd20, 64'd3, 0, 0, 64'd2);
    run_vec("op19", 0, 0, 19, 0, 64'd20, 64'd3, 0, 0, 64'd0);
    run_vec("pc4", 1, 2, 0, 0, 64'd20, 64'd3, 0, 64'h1000, 64'h1004);
    run_vec("passb0", 1, 3, 10, 0, 64'd20, 64'd3, 0, 64'h1000, 64'd0);
    run_vec("passimm", 0, 1, 10, 2, 64'd20, 64'd3, 64'h1234, 0, 64'h1234);

    // enable low with valid_i high: nothing captured
    enable = 0; valid_i = 1; busa_i = 64'hDEAD; ALUOp_i = 0;
    tick(); #1;
    check("nocap_alu", alu_res, 64'h1234);

    // CSR read-modify-write
    csr_wen = 1; csr_id = 12'h305; csr_op = 3'b001; csr_datain = 64'h8000_0100;
    #1;
    check("csr_preval", csr_rdata, 64'd0);
    csr_cmd(12'h305, 3'b001, 64'h8000_0100);
    check("mtvec_w", mtvec_o, 64'h8000_0100);
    csr_cmd(12'h305, 3'b010, 64'hF);
    check("mtvec_s", mtvec_o, 64'h8000_010F);
    csr_cmd(12'h305, 3'b011, 64'h3);
    check("mtvec_c", mtvec_o, 64'h8000_010C);
    csr_cmd(12'h305, 3'b100, 64'hFFFF);
    check("mtvec_nop", mtvec_o, 64'h8000_010C);
    csr_cmd(12'h123, 3'b001, 64'h5);
    check("unk_read", csr_rdata, 64'd0);
    csr_cmd(12'h341, 3'b101, 64'h44);
    check("mepc_wi", mepc_o, 64'h44);
    csr_cmd(12'h300, 3'b111, 64'h800);
    check("mstatus_ci", csr_rdata, 64'hA_0000_1000);

    // ecall trap overrides csr_op
    ecall = 1; epc_in = 64'h8000_0040;
    csr_cmd(12'h305, 3'b001, 64'd0);
    ecall = 0;
    check("ecall_mepc", mepc_o, 64'h8000_0040);
    check("ecall_mtvec", mtvec_o, 64'h8000_010C);
    csr_id = 12'h342; #1;
    check("ecall_mcause", csr_rdata, 64'd11);

    // reset mid-stream together with flush and enable
    enable = 1; valid_i = 1; busa_i = 64'd77; ALUSrcB_i = 0;
    tick();
    rst = 1; flush = 1;
    tick(); rst = 0; flush = 0; enable = 0;
    #1;
    check("mrst_valid", valid_o, 0);
    check("mrst_mtvec", mtvec_o, 0);
    check("mrst_mepc", mepc_o, 0);
    csr_id = 12'h300; #1;
    check("mrst_mstatus", csr_rdata, 64'hA_0000_1800);
    $display("midstream reset valid=%0b mstatus=%0h", valid_o, csr_rdata);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
